// File: rtl/adder_pipe.sv
// Pipelined add/sub: DW bits split into STAGES carry-chained chunks of DW/STAGES bits.
// Optional saturation on signed overflow is enabled by defining ADDER_PIPE_SAT_EN.
module adder_pipe #(
  parameter int DW     = 32,
  parameter int STAGES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  input  logic          cin,
  input  logic          sat,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          zero,
  output logic          overflow
);

  localparam int CW = DW / STAGES;
  localparam int L  = STAGES - 1;

  // Handshake: a beat moves on a rising edge where valid and ready are both high;
  // the producer keeps valid and payload steady until then. The whole pipe stalls
  // together, so ready upstream is simply "the output slot is free or being taken".
  logic advance;

  // Registered state of each stage; index L is the output stage.
  logic [DW-1:0] a_q [STAGES];
  logic [DW-1:0] b_q [STAGES];
  logic [DW-1:0] s_q [STAGES];
  logic          c_q [STAGES];
  logic          z_q [STAGES];
  logic          v_q [STAGES];
  logic          ovf_q;

  // Inputs seen by each stage and the values it will register.
  logic [DW-1:0] a_in [STAGES];
  logic [DW-1:0] b_in [STAGES];
  logic [DW-1:0] s_in [STAGES];
  logic          c_in [STAGES];
  logic          z_in [STAGES];
  logic          v_in [STAGES];
  logic [CW:0]   chunk [STAGES];
  logic [DW-1:0] s_nx [STAGES];
  logic          c_nx [STAGES];
  logic          z_nx [STAGES];
  logic          ovf_nx;

`ifdef ADDER_PIPE_SAT_EN
  logic sat_q  [STAGES];
  logic sat_in [STAGES];
`else
  logic unused_sat;
  assign unused_sat = sat;
`endif

  assign advance   = !v_q[L] || out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[L];
  assign result    = s_q[L];
  assign carry     = c_q[L];
  assign zero      = z_q[L];
  assign overflow  = ovf_q;

  always_comb begin
    a_in[0] = opa;
    b_in[0] = cin ? ~opb : opb;
    s_in[0] = '0;
    c_in[0] = cin;
    z_in[0] = 1'b1;
    v_in[0] = in_valid;
`ifdef ADDER_PIPE_SAT_EN
    sat_in[0] = sat;
`endif
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      z_in[k] = z_q[k-1];
      v_in[k] = v_q[k-1];
`ifdef ADDER_PIPE_SAT_EN
      sat_in[k] = sat_q[k-1];
`endif
    end

    for (int k = 0; k < STAGES; k++) begin
      chunk[k] = {1'b0, a_in[k][k*CW +: CW]} + {1'b0, b_in[k][k*CW +: CW]}
               + {{CW{1'b0}}, c_in[k]};
      s_nx[k]  = s_in[k];
      s_nx[k][k*CW +: CW] = chunk[k][CW-1:0];
      c_nx[k]  = chunk[k][CW];
      z_nx[k]  = z_in[k] && (chunk[k][CW-1:0] == '0);
    end

    // Signed overflow uses the inverted B, so opb = 0x80..0 under sub is covered.
    ovf_nx = (a_in[L][DW-1] == b_in[L][DW-1]) && (s_nx[L][DW-1] != a_in[L][DW-1]);

`ifdef ADDER_PIPE_SAT_EN
    if (sat_in[L] && ovf_nx) begin
      s_nx[L] = a_in[L][DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      z_nx[L] = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        z_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
`ifdef ADDER_PIPE_SAT_EN
        sat_q[k] <= 1'b0;
`endif
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= s_nx[k];
        c_q[k] <= c_nx[k];
        z_q[k] <= z_nx[k];
        v_q[k] <= v_in[k];
`ifdef ADDER_PIPE_SAT_EN
        sat_q[k] <= sat_in[k];
`endif
      end
      ovf_q <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe (DW=32, STAGES=4): directed steps plus random beats,
// with a scoreboard queue of {result, carry, zero, overflow} filled on accept.
module tb_adder_pipe;

  localparam int DW     = 32;
  localparam int STAGES = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic          cin;
  logic          sat;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic          carry;
  logic          zero;
  logic          overflow;

  adder_pipe #(.DW(DW), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opa(opa), .opb(opb), .cin(cin), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .zero(zero), .overflow(overflow)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int n_out  = 0;
  bit lat_chk = 1'b0;

  logic [DW+2:0] exp_in;
  logic [DW+2:0] exp_q[$];
  int            acc_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Independent reference: exact signed/unsigned arithmetic on wide integers.
  function automatic logic [DW+2:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic s);
    logic signed [33:0] exact;
    logic [32:0]        ua;
    logic [31:0]        r;
    logic               cy;
    logic               ov;
    exact = c ? ($signed({2'b0, a}) - $signed({2'b0, b})) : ($signed({2'b0, a}) + $signed({2'b0, b}));
    exact = c ? (34'($signed(a)) - 34'($signed(b))) : (34'($signed(a)) + 34'($signed(b)));
    ov    = (exact > 34'sh07FFFFFFF) || (exact < -34'sh080000000);
    ua    = {1'b0, a} + {1'b0, b};
    cy    = c ? (a >= b) : ua[32];
    r     = c ? (a - b) : (a + b);
`ifdef ADDER_PIPE_SAT_EN
    if (s && ov) r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    if (s && 1'b0) r = '0;
`endif
    return {r, cy, (r == 32'd0), ov};
  endfunction

  // scoreboard: pop on output transfer, push on input accept
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_out++;
        check("unexpected_output", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          check("result_flags", 64'({result, carry, zero, overflow}), 64'(exp_q.pop_front()));
          if (lat_chk) check("latency", 64'(cyc - acc_q.pop_front()), 64'(STAGES));
          else void'(acc_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(exp_in);
        acc_q.push_back(cyc);
      end
    end
  end

  // driver tasks
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c,
                      input logic s, input logic [DW+2:0] e);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    opa = a; opb = b; cin = c; sat = s; exp_in = e; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      opa = $urandom; opb = $urandom; cin = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    idle(1);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", 64'(ok), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic        s;
    logic [DW-1:0] held;
    int          out_before;
    bit          seen;

    // reset
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opa = '0; opb = '0; cin = 1'b0; sat = 1'b0; exp_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_carry", 64'(carry), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // directed arithmetic, latency checked
    lat_chk = 1'b1;
    send(32'h0000_FFFF, 32'h1, 1'b0, 1'b0, {32'h0001_0000, 1'b0, 1'b0, 1'b0});
    drain();
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, {32'h0, 1'b1, 1'b1, 1'b0});
    send(32'h5, 32'h5, 1'b1, 1'b0, {32'h0, 1'b1, 1'b1, 1'b0});
    send(32'h3, 32'h5, 1'b1, 1'b0, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
    send(32'h8000_0000, 32'h1, 1'b1, 1'b0, {32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1});
    send(32'h0, 32'h8000_0000, 1'b1, 1'b0, {32'h8000_0000, 1'b0, 1'b0, 1'b1});
`ifdef ADDER_PIPE_SAT_EN
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, {32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1});
    send(32'h8000_0000, 32'h1, 1'b1, 1'b1, {32'h8000_0000, 1'b1, 1'b0, 1'b1});
`else
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, {32'h8000_0000, 1'b0, 1'b0, 1'b1});
    send(32'h8000_0000, 32'h1, 1'b1, 1'b1, {32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1});
`endif
    send(32'h1, 32'h1, 1'b0, 1'b1, {32'h2, 1'b0, 1'b0, 1'b0});
    drain();

    // backpressure: 8 back-to-back beats, out_ready low for 3 cycles mid-stream
    lat_chk = 1'b0;
    out_before = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(32'(i), 32'(i), 1'b0, 1'b0, {32'(2 * i), 1'b0, (i == 0), 1'b0});
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        check("bp_first_output", 64'(seen), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          if (j == 0) held = result;
          check("bp_in_ready", 64'(in_ready), 64'd0);
          check("bp_out_valid_hold", 64'(out_valid), 64'd1);
          check("bp_result_hold", 64'(result), 64'(held));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_back", 64'(in_ready), 64'd1);
      end
    join
    drain();
    check("bp_count", 64'(n_out - out_before), 64'd8);

    // reset while 3 beats are in flight
    out_before = n_out;
    for (int i = 0; i < 3; i++)
      send(32'(100 + i), 32'h1, 1'b0, 1'b0, {32'(101 + i), 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_output", 64'(seen), 64'd0);
    check("flush_count", 64'(n_out - out_before), 64'd0);

    // random beats with gaps, latency checked
    lat_chk = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) b = a;
      if (i % 6 == 1) a = 32'h8000_0000;
      c = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      send(a, b, c, s, model(a, b, c, s));
      if ($urandom_range(0, 3) == 0) idle(32'($urandom_range(1, 3)));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Pipelined, parametrised add/sub unit. Successor to the single-cycle combinational adder.
- Splits a DW-bit add/sub into STAGES carry-chained chunks and registers the carry between stages, so the adder can run at a higher clock.
- Valid/ready handshake on both sides. Produces the same flags as the combinational unit: carry, zero, overflow.
- Sits between operand select and writeback in the multi-cycle datapath.

Parameters:
- DW, 32, operand/result width.
- STAGES, 4, pipeline depth. Must divide DW; CW = DW/STAGES bits are summed per stage. STAGES=1 is legal (one registered stage).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit accepts a beat this cycle.
- opa  input  DW  operand A.
- opb  input  DW  operand B.
- cin  input  1  0 = opa+opb, 1 = opa-opb.
- sat  input  1  saturate request; only used when ADDER_PIPE_SAT_EN is defined.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- result  output  DW  sum/difference.
- carry  output  1  carry-out of the MSB chunk.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow.

Behaviour:
- Reset (rst_n=0 at a clk edge): all stage valid bits, out_valid, result, carry, zero and overflow clear to 0. in_ready reads 1 on the first cycle after reset.
- Reset mid-operation: every in-flight beat is discarded and none is emitted.
- Flow control:
  - advance = !out_valid | out_ready; in_ready = advance (global stall, no bubbles squeezed).
  - A beat is accepted when in_valid & in_ready.
  - While advance=0 all stage registers hold; out_valid and the result fields stay stable until taken.
- Latency: exactly STAGES cycles from accept to out_valid when not stalled. Throughput is 1 beat/cycle. Order is preserved.
- Arithmetic:
  - B' = cin ? ~opb : opb. Chunk 0 carry-in = cin.
  - Stage k sums opa[k*CW +: CW] + B'[k*CW +: CW] + c(k-1) and registers the CW-bit sum chunk, the carry-out, and a running zero flag (AND of per-chunk zero).
  - Not-yet-used upper chunks of opa and B' are carried forward in registers; finished lower sum chunks are carried forward too.
- Flags at the output stage:
  - carry = carry-out of the full DW-bit sum opa+B'+cin. For sub, carry=1 means no borrow, i.e. opa >= opb unsigned.
  - zero = (result == 0), computed on the final (post-saturation) result.
  - overflow = (opa[DW-1] == B'[DW-1]) & (sum[DW-1] != opa[DW-1]). This is the true signed overflow of opa±opb, including the case opb = 0x80..0 under sub.
- Simultaneous events:
  - Accept and emit in the same cycle is legal when out_ready=1.
  - in_valid=0 during advance inserts a bubble (stage valid=0). Bubbles never produce out_valid.
- The opa/opb/cin/sat inputs are sampled only on accept; they are don't-care otherwise.

Optional Feature:
- Macro ADDER_PIPE_SAT_EN.
- Defined: on the final stage, if sat=1 and overflow=1, result clamps to 0x7F..F when opa[DW-1]=0, else to 0x80..0. overflow still reports 1; carry is unchanged (raw carry); zero is evaluated on the clamped result. sat is registered along the pipeline with each beat.
- Undefined: the sat port exists but is ignored. result is the wrapped DW-bit sum.

Test Plan (DW=32, STAGES=4):
- Reset: hold rst_n=0 for 2 edges, release -> out_valid=0, result=0, carry=zero=overflow=0, in_ready=1.
- Cross-chunk carry: add 0x0000FFFF + 0x00000001, out_ready=1 -> exactly 4 cycles after accept: result=0x00010000, carry=0, zero=0, overflow=0. Add 0xFFFFFFFF + 1 -> result=0, carry=1, zero=1, overflow=0.
- Sub flags:
  - 5-5 -> result=0, zero=1, carry=1, overflow=0.
  - 3-5 -> 0xFFFFFFFE, carry=0.
  - 0x80000000-1 -> 0x7FFFFFFF, overflow=1, carry=1.
  - 0-0x80000000 -> 0x80000000, overflow=1.
- Backpressure: stream 8 back-to-back beats (opa=i, opb=i, add); drop out_ready for 3 cycles mid-stream -> in_ready=0 in those exact cycles, output holds stable, all 8 results 2*i delivered in order, none lost or duplicated.
- Reset mid-flight: accept 3 beats, assert rst_n=0 for 1 edge -> out_valid stays 0 and none of the 3 results ever appears.
- Saturation: add 0x7FFFFFFF + 1 with sat=1 -> with ADDER_PIPE_SAT_EN: result=0x7FFFFFFF, overflow=1; without: result=0x80000000, overflow=1. Sub 0x80000000-1 with sat=1 and macro on -> result=0x80000000, overflow=1.
